// File: rtl/ram_ctrl_pkg.sv
// Shared types and default sizes for the burst RAM controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package ram_ctrl_pkg;

  localparam int AW_DEF = 4;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

endpackage

// File: rtl/ram_burst_ctr.sv
// Burst address/beat counter shared by the write and read paths.
// Latency: load and advance take effect on the next rising edge.
// Backpressure: holds its value whenever advance is low.
module ram_burst_ctr
  import ram_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] load_addr,
  input  logic [AW-1:0] load_len,
  input  logic          advance,
  output logic [AW-1:0] cur_addr,
  output logic [AW-1:0] remaining,
  output logic          last
);

  // Address wraps naturally at AW bits; remaining counts beats left minus one.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr  <= '0;
      remaining <= '0;
    end else if (load) begin
      cur_addr  <= load_addr;
      remaining <= load_len;
    end else if (advance) begin
      cur_addr  <= cur_addr + 1'b1;
      remaining <= remaining - 1'b1;
    end
  end

  assign last = (remaining == '0);

endmodule

// File: rtl/ram_ctrl.sv
// Burst read/write controller acting as sole initiator on a 16x8 register-file RAM.
// Latency: write beat lands at end of its accept cycle; first read beat 2 cycles after command.
// Backpressure: valid/ready on cmd, wdata and rdata; a stalled rdata freezes address and count.
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_wr,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  input  logic [DW-1:0] wdata,
  input  logic          wdata_valid,
  output logic          wdata_ready,
  output logic [DW-1:0] rdata,
  output logic          rdata_valid,
  input  logic          rdata_ready,
  output logic          busy,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_wr_en,
  input  logic [DW-1:0] ram_dout
);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] cur_addr;
  logic [AW-1:0] remaining;
  logic          last;
  logic          accept;
  logic          wr_beat;
  logic          rd_cap;

  // Handshake readiness is gated by rst so nothing transfers on a reset edge.
  assign cmd_ready   = (state == IDLE)  && !rst;
  assign wdata_ready = (state == WRITE) && !rst;
  assign accept      = cmd_valid && cmd_ready;
  assign wr_beat     = wdata_valid && wdata_ready;
  // A read beat is captured whenever the output register is empty or being drained.
  assign rd_cap      = (state == READ) && (!rdata_valid || rdata_ready);
  assign ram_addr    = cur_addr;

  ram_burst_ctr #(.AW(AW)) u_ctr (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_addr (cmd_addr),
    .load_len  (cmd_len),
    .advance   (wr_beat || rd_cap),
    .cur_addr  (cur_addr),
    .remaining (remaining),
    .last      (last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and RAM write-port muxing.
  always_comb begin
    state_nxt = state;
    ram_wr_en = 1'b0;
    ram_din   = '0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = cmd_wr ? WRITE : READ;
      end
      WRITE: begin
        busy      = 1'b1;
        ram_wr_en = wdata_valid && !rst;
        ram_din   = wdata;
        if (wr_beat && last) state_nxt = IDLE;
      end
      READ: begin
        busy = 1'b1;
        if (rd_cap && last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read output register; a pending beat outlives the burst until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else if (rd_cap) begin
      rdata       <= ram_dout;
      rdata_valid <= 1'b1;
    end else if (rdata_ready) begin
      rdata_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl with a 16x8 register-file RAM model on its port.
module tb_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_wr;
  logic [3:0] cmd_addr;
  logic [3:0] cmd_len;
  logic [7:0] wdata;
  logic       wdata_valid;
  logic       wdata_ready;
  logic [7:0] rdata;
  logic       rdata_valid;
  logic       rdata_ready;
  logic       busy;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic       ram_wr_en;
  logic [7:0] ram_dout;

  logic [7:0] mem [16];
  int         wr_count;
  int         passed = 0;
  int         total  = 0;

  always #5 clk = ~clk;

  ram_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_wr      (cmd_wr),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .wdata       (wdata),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .rdata_ready (rdata_ready),
    .busy        (busy),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din),
    .ram_wr_en   (ram_wr_en),
    .ram_dout    (ram_dout)
  );

  // RAM model: combinational read, write committed on the clock edge.
  assign ram_dout = mem[ram_addr];

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'hC0 + 8'(i);
    wr_count = 0;
  end

  always @(posedge clk) begin
    if (ram_wr_en) begin
      mem[ram_addr] <= ram_din;
      wr_count      <= wr_count + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    int base;
    logic [3:0] waddr [4];

    rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdata = '0; wdata_valid = 1'b0; rdata_ready = 1'b0;
    tick();
    settle();
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    tick(); tick();
    rst = 1'b0;
    settle();
    // first cycle after release
    chk("post_rst_cmd_ready", 32'(cmd_ready), 1);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_rdata_valid", 32'(rdata_valid), 0);
    chk("post_rst_wr_en", 32'(ram_wr_en), 0);
    chk("post_rst_ram_addr", 32'(ram_addr), 0);
    chk("post_rst_ram_din", 32'(ram_din), 0);

    // single write addr 3 = A5
    cmd_valid = 1; cmd_wr = 1; cmd_addr = 4'd3; cmd_len = 4'd0;
    tick();
    cmd_valid = 0; wdata = 8'hA5; wdata_valid = 1;
    settle();
    chk("w1_wdata_ready", 32'(wdata_ready), 1);
    chk("w1_wr_en", 32'(ram_wr_en), 1);
    chk("w1_addr", 32'(ram_addr), 3);
    chk("w1_din", 32'(ram_din), 32'hA5);
    chk("w1_busy", 32'(busy), 1);
    tick();
    wdata_valid = 0;
    settle();
    chk("w1_idle_busy", 32'(busy), 0);
    chk("w1_wr_en_off", 32'(ram_wr_en), 0);
    chk("w1_mem3", 32'(mem[3]), 32'hA5);
    chk("w1_count", 32'(wr_count), 1);

    // single read addr 3
    cmd_valid = 1; cmd_wr = 0; cmd_addr = 4'd3; cmd_len = 4'd0; rdata_ready = 1;
    settle();
    chk("r1_cmd_ready", 32'(cmd_ready), 1);
    tick();
    cmd_valid = 0;
    settle();
    chk("r1_t1_addr", 32'(ram_addr), 3);
    chk("r1_t1_wr_en", 32'(ram_wr_en), 0);
    chk("r1_t1_rvalid", 32'(rdata_valid), 0);
    chk("r1_t1_busy", 32'(busy), 1);
    tick();
    settle();
    chk("r1_t2_rvalid", 32'(rdata_valid), 1);
    chk("r1_t2_rdata", 32'(rdata), 32'hA5);
    chk("r1_t2_busy", 32'(busy), 0);
    tick();
    settle();
    chk("r1_drained", 32'(rdata_valid), 0);

    // wrapping write burst 14,15,0,1
    waddr[0] = 4'd14; waddr[1] = 4'd15; waddr[2] = 4'd0; waddr[3] = 4'd1;
    cmd_valid = 1; cmd_wr = 1; cmd_addr = 4'd14; cmd_len = 4'd3;
    tick();
    cmd_valid = 0; wdata_valid = 1;
    for (int i = 0; i < 4; i++) begin
      wdata = 8'h10 + 8'(i);
      settle();
      chk($sformatf("w2_addr%0d", i), 32'(ram_addr), 32'(waddr[i]));
      chk($sformatf("w2_wr_en%0d", i), 32'(ram_wr_en), 1);
      tick();
    end
    wdata_valid = 0;
    settle();
    chk("w2_busy_end", 32'(busy), 0);
    chk("w2_count", 32'(wr_count), 5);
    chk("w2_mem14", 32'(mem[14]), 32'h10);
    chk("w2_mem15", 32'(mem[15]), 32'h11);
    chk("w2_mem0", 32'(mem[0]), 32'h12);
    chk("w2_mem1", 32'(mem[1]), 32'h13);

    // wrapping read burst, consumer always ready
    cmd_valid = 1; cmd_wr = 0; cmd_addr = 4'd14; cmd_len = 4'd3; rdata_ready = 1;
    tick();
    cmd_valid = 0;
    settle();
    chk("r2_t1_rvalid", 32'(rdata_valid), 0);
    chk("r2_t1_addr", 32'(ram_addr), 14);
    tick();
    for (int i = 0; i < 4; i++) begin
      settle();
      chk($sformatf("r2_rvalid%0d", i), 32'(rdata_valid), 1);
      chk($sformatf("r2_rdata%0d", i), 32'(rdata), 32'h10 + 32'(i));
      tick();
    end
    settle();
    chk("r2_drained", 32'(rdata_valid), 0);
    chk("r2_busy", 32'(busy), 0);

    // read addr 0 len 2 with 3 stalled cycles after the first beat
    cmd_valid = 1; cmd_wr = 0; cmd_addr = 4'd0; cmd_len = 4'd2; rdata_ready = 0;
    tick();
    cmd_valid = 0;
    tick();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("r3_hold_valid%0d", i), 32'(rdata_valid), 1);
      chk($sformatf("r3_hold_data%0d", i), 32'(rdata), 32'h12);
      chk($sformatf("r3_hold_addr%0d", i), 32'(ram_addr), 1);
      tick();
    end
    rdata_ready = 1;
    settle();
    chk("r3_beat0", 32'(rdata), 32'h12);
    tick();
    settle();
    chk("r3_beat1", 32'(rdata), 32'h13);
    chk("r3_beat1_valid", 32'(rdata_valid), 1);
    tick();
    settle();
    chk("r3_beat2", 32'(rdata), 32'hC2);
    chk("r3_beat2_valid", 32'(rdata_valid), 1);
    chk("r3_busy_end", 32'(busy), 0);
    tick();
    settle();
    chk("r3_drained", 32'(rdata_valid), 0);

    // write addr 8 len 3 with wdata_valid on alternate cycles
    base = wr_count;
    cmd_valid = 1; cmd_wr = 1; cmd_addr = 4'd8; cmd_len = 4'd3;
    tick();
    cmd_valid = 0;
    for (int i = 0; i < 8; i++) begin
      wdata_valid = (i % 2 == 1);
      wdata = 8'h20 + 8'(i / 2);
      settle();
      chk($sformatf("w4_wr_en%0d", i), 32'(ram_wr_en), 32'(i % 2));
      chk($sformatf("w4_busy%0d", i), 32'(busy), 1);
      tick();
    end
    wdata_valid = 0;
    settle();
    chk("w4_busy_end", 32'(busy), 0);
    chk("w4_count", 32'(wr_count - base), 4);
    chk("w4_mem8", 32'(mem[8]), 32'h20);
    chk("w4_mem11", 32'(mem[11]), 32'h23);

    // reset after two beats of a four-beat write burst at addr 4
    base = wr_count;
    cmd_valid = 1; cmd_wr = 1; cmd_addr = 4'd4; cmd_len = 4'd3;
    tick();
    cmd_valid = 0; wdata_valid = 1;
    wdata = 8'h30; tick();
    wdata = 8'h31; tick();
    wdata = 8'h32; rst = 1;
    settle();
    chk("rb_rst_wr_en0", 32'(ram_wr_en), 0);
    chk("rb_rst_wready0", 32'(wdata_ready), 0);
    chk("rb_rst_cmd_ready", 32'(cmd_ready), 0);
    tick();
    wdata = 8'h33;
    settle();
    chk("rb_rst_wr_en1", 32'(ram_wr_en), 0);
    tick();
    rst = 0;
    settle();
    chk("rb_cmd_ready", 32'(cmd_ready), 1);
    chk("rb_busy", 32'(busy), 0);
    chk("rb_wr_en_after", 32'(ram_wr_en), 0);
    tick();
    wdata_valid = 0;
    chk("rb_count", 32'(wr_count - base), 2);
    chk("rb_mem4", 32'(mem[4]), 32'h30);
    chk("rb_mem5", 32'(mem[5]), 32'h31);
    cmd_valid = 1; cmd_wr = 0; cmd_addr = 4'd6; cmd_len = 4'd1; rdata_ready = 1;
    tick();
    cmd_valid = 0;
    tick();
    settle();
    chk("rb_rd6", 32'(rdata), 32'hC6);
    tick();
    settle();
    chk("rb_rd7", 32'(rdata), 32'hC7);
    chk("rb_rd7_valid", 32'(rdata_valid), 1);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ram_ctrl.md
# ram_ctrl

Burst-capable access controller that sits in front of the 16x8 register-file RAM and acts as the sole initiator on its port. It accepts read/write burst commands over a valid/ready handshake and streams write data in and read data out with backpressure. It generates the RAM address, data and write-enable, and handles address wrap-around.

## Interface
- AW, 4: RAM address width (16 locations)
- DW, 8: RAM data width
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_wr  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  AW  start address
- cmd_len  in  AW  beats minus one (0..15)
- wdata  in  DW  write beat data
- wdata_valid  in  1  write beat present
- wdata_ready  out  1  controller consumes write beat this cycle
- rdata  out  DW  read beat data (registered)
- rdata_valid  out  1  rdata holds an unconsumed beat
- rdata_ready  in  1  consumer takes rdata this cycle
- busy  out  1  burst in progress (state != IDLE)
- ram_addr  out  AW  RAM address
- ram_din  out  DW  RAM write data
- ram_wr_en  out  1  RAM write enable; RAM commits on clk edge
- ram_dout  in  DW  RAM read data, combinational from ram_addr when ram_wr_en=0

## Operation
- States: IDLE, WRITE, READ.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch addr into cur_addr and cmd_len into remaining. Go to WRITE if cmd_wr=1, else READ.
- WRITE: wdata_ready=1. ram_addr=cur_addr, ram_din=wdata, ram_wr_en=wdata_valid (combinational). Each accepted beat: cur_addr+1 mod 16, remaining-1. The beat accepted with remaining=0 returns to IDLE.
- READ: ram_wr_en=0, ram_addr=cur_addr. A beat is captured when (!rdata_valid || rdata_ready): rdata<=ram_dout, rdata_valid<=1, and address/count advance. The beat captured with remaining=0 returns to IDLE.
- rdata_valid clears on rdata_ready when no new capture happens in that cycle.
- A pending rdata beat survives the return to IDLE. A new command may be accepted while it is pending.
- Outside WRITE: ram_wr_en=0, wdata_ready=0. ram_din=0 outside WRITE.
- Address arithmetic is AW-bit unsigned and wraps 15→0 silently. The burst length is not checked against the address space: a 16-beat burst covers every location exactly once.
- busy=1 in WRITE and READ.

## Timing
- Reset values: state=IDLE, cur_addr=0, remaining=0, rdata=0, rdata_valid=0, ram_addr=0, ram_din=0.
- While rst=1, cmd_ready, wdata_ready and ram_wr_en are forced 0 combinationally. No RAM write occurs on any edge where rst=1.
- Reset mid-burst aborts the burst. Beats not yet transferred are dropped. The cycle after rst deasserts, cmd_ready=1.
- Write latency: command accepted in cycle T; first wdata_ready in T+1; the RAM location is updated at the end of the cycle in which the beat is accepted.
- Read latency: command accepted in T; ram_addr valid in T+1; rdata_valid=1 with first beat in T+2.
- Throughput: one beat per cycle when wdata_valid or rdata_ready is held high.
- Backpressure: while rdata_valid=1 and rdata_ready=0, rdata, ram_addr and remaining hold stable.
- Back-to-back: IDLE lasts at least one cycle between bursts, so a new command is accepted at the earliest one cycle after the last beat.

## Structure
- Package ram_ctrl_pkg holds the state enum (IDLE, WRITE, READ) and the AW/DW default constants.
- One natural sub-module: ram_burst_ctr. It holds the cur_addr/remaining registers and provides load, advance and last outputs. It is shared by the WRITE and READ paths.
- The top level contains the FSM, the rdata output register and the RAM port muxing.

## Test plan
- Release reset -> cmd_ready=1, busy=0, rdata_valid=0, ram_wr_en=0, ram_addr=0 on the first cycle after rst drops.
- Write addr 3, len 0, data 0xA5; then read addr 3, len 0 -> ram_wr_en pulses once with ram_addr=3; read returns rdata=0xA5 with rdata_valid at T+2.
- Write burst addr 14, len 3, data 0x10..0x13; then read burst addr 14, len 3 -> writes land at 14,15,0,1; reads return 0x10,0x11,0x12,0x13 on consecutive cycles with rdata_ready=1.
- Read burst addr 0, len 2, with rdata_ready=0 for 3 cycles after the first beat -> rdata holds the first beat and ram_addr holds 1; all 3 beats are delivered in order with none lost or duplicated.
- Write burst len 3 with wdata_valid low on alternate cycles -> ram_wr_en is high only on valid cycles; exactly 4 writes occur; busy falls after the 4th.
- Assert rst after 2 beats of a 4-beat write burst -> no ram_wr_en while rst=1 or afterwards; cmd_ready=1 the cycle after release; a following read of the 3rd/4th addresses shows they were not written by this burst.
